pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Sequential consumer of the PC-source select and kill produced by the decode-stage PC control logic.
- Holds the program counter and drives the instruction-memory address.
- Registers the fetched instruction into the IF/ID pipeline register, and inserts a bubble on a kill.
- Optionally keeps a hardware return-address stack (RAS) that resolves Ret targets and records call return addresses.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- RAS_DEPTH, 8, number of return-address stack entries (power of 2, minimum 2).
- NOP_INSTR, 32'h0000_0000, instruction word placed in IF/ID on a bubble.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- PcSource  input  3  000 Pc+4, 001 jump/call, 010 branch, 011 call rs1, 100 ret.
- SIG_Kill  input  1  redirect taken; flush the IF-stage instruction.
- SIG_Call  input  1  the decoded instruction is a Call (qualifies PcSource 001 as a push).
- SIG_Stall  input  1  decode hazard; freeze PC and IF/ID.
- JumpTarget  input  32  target for PcSource 001.
- BranchTarget  input  32  target for PcSource 010.
- Rs1Target  input  32  target for PcSource 011.
- RetTarget  input  32  ret target, used only when RAS_EN is undefined.
- InstrIn  input  32  instruction memory read data for address Pc (combinational read).
- Pc  output  32  current fetch address.
- IfId_Instr  output  32  registered instruction.
- IfId_Pc  output  32  registered address of IfId_Instr.
- IfId_Valid  output  1  IF/ID holds a real instruction.
- RasOverflow  output  1  sticky; a push occurred while the RAS was full.
- RasUnderflow  output  1  sticky; a pop occurred while the RAS was empty.

Behaviour:
- Reset is synchronous: evaluated on the clk edge while rst_n=0.
  - Pc=RESET_PC, IfId_Instr=NOP_INSTR, IfId_Pc=RESET_PC, IfId_Valid=0.
  - RAS count=0, RasOverflow=0, RasUnderflow=0.
  - Reset overrides every other input and aborts any pending redirect.
- Next-PC mux, combinational:
  - 000 gives Pc+4, with 32-bit wrap (32'hFFFF_FFFC+4=0).
  - 001 gives JumpTarget; 010 gives BranchTarget; 011 gives Rs1Target.
  - 100 gives the RAS top, or RetTarget without RAS_EN.
  - 101-111 give Pc+4.
- Stall (SIG_Stall=1) has priority over redirect:
  - Pc, IF/ID and RAS all hold.
  - PcSource, SIG_Kill and SIG_Call are ignored; decode re-presents them after the stall.
- No stall: Pc <= next-PC every cycle.
  - If SIG_Kill=0: IfId_Instr<=InstrIn, IfId_Pc<=Pc, IfId_Valid<=1.
  - If SIG_Kill=1: IfId_Instr<=NOP_INSTR, IfId_Pc<=Pc, IfId_Valid<=0. Exactly one wrong-path instruction is dropped.
- Latency: a redirect presented in cycle N makes Pc equal the target after edge N. The first target instruction is valid in IF/ID after edge N+1.
- SIG_Kill with PcSource=000 still flushes (one bubble); Pc still advances to Pc+4.
- RAS (RAS_EN only):
  - Circular buffer with write pointer and count (0..RAS_DEPTH).
  - A push happens when not stalled and either (PcSource=001 and SIG_Call=1) or PcSource=011.
    - Pushed value = IfId_Pc+4.
    - Pointer increments with wrap; count saturates at RAS_DEPTH.
    - Push while count=RAS_DEPTH overwrites the oldest entry and sets RasOverflow.
  - A pop happens when not stalled and PcSource=100.
    - Ret target = the entry at pointer-1; pointer decrements and count decrements.
  - Pop with count=0: target = RESET_PC, pointer and count unchanged, RasUnderflow set.
  - Push and pop never coincide, because PcSource encodes only one action per cycle.
  - The flags clear only on reset.

Optional Feature:
- Macro: PC_FETCH_RAS_EN.
- Defined: the RAS is built as described above, and Ret target = RAS top.
- Undefined:
  - No RAS storage; the Ret target is the RetTarget input.
  - SIG_Call is ignored.
  - RasOverflow and RasUnderflow are tied to 0.

Test Plan:
- Reset, then 4 cycles of PcSource=000 with no kill -> Pc=0,4,8,C,10. IfId_Valid=0 after the first edge, then 1. IfId_Pc lags Pc by one cycle.
- With Pc=0x10, present PcSource=010, SIG_Kill=1, BranchTarget=0x80 for one cycle -> next Pc=0x80, IfId_Valid=0, IfId_Instr=NOP. The next cycle gives IfId_Pc=0x80, IfId_Valid=1.
- Hold SIG_Stall=1 for 3 cycles while PcSource=001 and SIG_Kill=1 -> Pc, IF/ID and RAS unchanged. On release with the jump still presented, Pc=JumpTarget.
- RAS_EN: with IfId_Pc=0x20, issue a Call (PcSource=001, SIG_Call=1, JumpTarget=0x100). Later issue PcSource=100 -> Pc=0x24, count returns to 0, no flags set.
- RAS_EN, RAS_DEPTH=8: 9 pushes, then 9 pops -> RasOverflow=1 after the 9th push. Pops 1-8 return the 8 newest addresses, newest first. Pop 9 gives Pc=RESET_PC and RasUnderflow=1.
- Pc=0xFFFF_FFFC with PcSource=000 -> Pc wraps to 0x0000_0000. Assert rst_n=0 during a kill -> all outputs take their reset values on that edge.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Fetch stage: program counter, next-PC selection and the IF/ID pipeline register.
// Define PC_FETCH_RAS_EN to build the hardware return-address stack for Ret targets.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          RAS_DEPTH = 8,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  PcSource,
    input  logic        SIG_Kill,
    input  logic        SIG_Call,
    input  logic        SIG_Stall,
    input  logic [31:0] JumpTarget,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] Rs1Target,
    input  logic [31:0] RetTarget,
    input  logic [31:0] InstrIn,
    output logic [31:0] Pc,
    output logic [31:0] IfId_Instr,
    output logic [31:0] IfId_Pc,
    output logic        IfId_Valid,
    output logic        RasOverflow,
    output logic        RasUnderflow
);

    localparam logic [2:0] SRC_SEQ    = 3'b000;
    localparam logic [2:0] SRC_JUMP   = 3'b001;
    localparam logic [2:0] SRC_BRANCH = 3'b010;
    localparam logic [2:0] SRC_RS1    = 3'b011;
    localparam logic [2:0] SRC_RET    = 3'b100;

    logic [31:0] pc_plus4;
    logic [31:0] ret_target;
    logic [31:0] next_pc;

    assign pc_plus4 = Pc + 32'd4;

    always_comb begin
        next_pc = pc_plus4;
        case (PcSource)
            SRC_SEQ:    next_pc = pc_plus4;
            SRC_JUMP:   next_pc = JumpTarget;
            SRC_BRANCH: next_pc = BranchTarget;
            SRC_RS1:    next_pc = Rs1Target;
            SRC_RET:    next_pc = ret_target;
            default:    next_pc = pc_plus4;
        endcase
    end

    // A stall freezes everything; redirects are re-presented by decode afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Pc         <= RESET_PC;
            IfId_Instr <= NOP_INSTR;
            IfId_Pc    <= RESET_PC;
            IfId_Valid <= 1'b0;
        end else if (!SIG_Stall) begin
            Pc      <= next_pc;
            IfId_Pc <= Pc;
            if (SIG_Kill) begin
                IfId_Instr <= NOP_INSTR;
                IfId_Valid <= 1'b0;
            end else begin
                IfId_Instr <= InstrIn;
                IfId_Valid <= 1'b1;
            end
        end
    end

`ifdef PC_FETCH_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PTR_W:0] RAS_FULL = (PTR_W+1)'(RAS_DEPTH);

    logic [31:0]      ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;
    logic [PTR_W-1:0] ras_top_idx;
    logic [PTR_W:0]   ras_cnt;
    logic             ras_push;
    logic             ras_pop;
    logic             ras_empty;
    logic [31:0]      unused_ret;

    assign unused_ret  = RetTarget;
    assign ras_top_idx = ras_ptr - 1'b1;
    assign ras_empty   = (ras_cnt == '0);
    assign ras_push    = !SIG_Stall &&
                         (((PcSource == SRC_JUMP) && SIG_Call) || (PcSource == SRC_RS1));
    assign ras_pop     = !SIG_Stall && (PcSource == SRC_RET);
    assign ret_target  = ras_empty ? RESET_PC : ras_mem[ras_top_idx];

    // The call being decoded sits in IF/ID, so its return address is IfId_Pc+4.
    always_ff @(posedge clk) begin
        if (ras_push) begin
            ras_mem[ras_ptr] <= IfId_Pc + 32'd4;
        end
    end

    // Full pushes overwrite the oldest entry; empty pops leave pointer and count alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ras_ptr      <= '0;
            ras_cnt      <= '0;
            RasOverflow  <= 1'b0;
            RasUnderflow <= 1'b0;
        end else if (ras_push) begin
            ras_ptr <= ras_ptr + 1'b1;
            if (ras_cnt == RAS_FULL) begin
                RasOverflow <= 1'b1;
            end else begin
                ras_cnt <= ras_cnt + 1'b1;
            end
        end else if (ras_pop) begin
            if (ras_empty) begin
                RasUnderflow <= 1'b1;
            end else begin
                ras_ptr <= ras_top_idx;
                ras_cnt <= ras_cnt - 1'b1;
            end
        end
    end
`else
    logic unused_call;

    assign unused_call  = SIG_Call;
    assign ret_target   = RetTarget;
    assign RasOverflow  = 1'b0;
    assign RasUnderflow = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequencing, kill bubbles, stall, Ret targets, wrap and reset.
module tb_pc_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  pc_source;
    logic        sig_kill;
    logic        sig_call;
    logic        sig_stall;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [31:0] rs1_target;
    logic [31:0] ret_target;
    logic [31:0] instr_in;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic        ifid_valid;
    logic        ras_overflow;
    logic        ras_underflow;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .RAS_DEPTH(8),
        .NOP_INSTR(NOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PcSource    (pc_source),
        .SIG_Kill    (sig_kill),
        .SIG_Call    (sig_call),
        .SIG_Stall   (sig_stall),
        .JumpTarget  (jump_target),
        .BranchTarget(branch_target),
        .Rs1Target   (rs1_target),
        .RetTarget   (ret_target),
        .InstrIn     (instr_in),
        .Pc          (pc),
        .IfId_Instr  (ifid_instr),
        .IfId_Pc     (ifid_pc),
        .IfId_Valid  (ifid_valid),
        .RasOverflow (ras_overflow),
        .RasUnderflow(ras_underflow)
    );

    function automatic logic [31:0] imem(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    assign instr_in = imem(pc);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] src, input logic kill, input logic call, input logic stall);
        pc_source = src;
        sig_kill  = kill;
        sig_call  = call;
        sig_stall = stall;
    endtask

    task automatic test_reset();
        branch_target = 32'hDEAD_BEE0;
        drive(3'b010, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h want %h", pc, 32'h0); else n_pass++;
        n_checks++; if (ifid_pc !== 32'h0) $display("FAIL reset_ifid_pc: got %h want %h", ifid_pc, 32'h0); else n_pass++;
        n_checks++; if (ifid_instr !== NOP) $display("FAIL reset_instr: got %h want %h", ifid_instr, NOP); else n_pass++;
        n_checks++; if (ifid_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ifid_valid); else n_pass++;
        n_checks++; if (ras_overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ras_overflow); else n_pass++;
        n_checks++; if (ras_underflow !== 1'b0) $display("FAIL reset_unf: got %b want 0", ras_underflow); else n_pass++;
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_checks++; if (pc !== 32'(4*i)) $display("FAIL seq_pc: got %h want %h", pc, 32'(4*i)); else n_pass++;
            n_checks++; if (ifid_pc !== 32'(4*(i-1))) $display("FAIL seq_ifid_pc: got %h want %h", ifid_pc, 32'(4*(i-1))); else n_pass++;
            n_checks++; if (ifid_valid !== 1'b1) $display("FAIL seq_valid: got %b want 1", ifid_valid); else n_pass++;
            n_checks++; if (ifid_instr !== imem(32'(4*(i-1)))) $display("FAIL seq_instr: got %h want %h", ifid_instr, imem(32'(4*(i-1)))); else n_pass++;
        end
    endtask

    task automatic test_branch_kill();
        branch_target = 32'h80;
        drive(3'b010, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++; if (pc !== 32'h80) $display("FAIL br_pc: got %h want %h", pc, 32'h80); else n_pass++;
        n_checks++; if (ifid_valid !== 1'b0) $display("FAIL br_bubble_valid: got %b want 0", ifid_valid); else n_pass++;
        n_checks++; if (ifid_instr !== NOP) $display("FAIL br_bubble_instr: got %h want %h", ifid_instr, NOP); else n_pass++;
        n_checks++; if (ifid_pc !== 32'h10) $display("FAIL br_bubble_pc: got %h want %h", ifid_pc, 32'h10); else n_pass++;
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++; if (ifid_pc !== 32'h80) $display("FAIL br_target_ifid_pc: got %h want %h", ifid_pc, 32'h80); else n_pass++;
        n_checks++; if (ifid_valid !== 1'b1) $display("FAIL br_target_valid: got %b want 1", ifid_valid); else n_pass++;
        n_checks++; if (ifid_instr !== imem(32'h80)) $display("FAIL br_target_instr: got %h want %h", ifid_instr, imem(32'h80)); else n_pass++;
        n_checks++; if (pc !== 32'h84) $display("FAIL br_next_pc: got %h want %h", pc, 32'h84); else n_pass++;
        // Kill on a sequential source still flushes one slot.
        drive(3'b000, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++; if (pc !== 32'h88) $display("FAIL seqkill_pc: got %h want %h", pc, 32'h88); else n_pass++;
        n_checks++; if (ifid_valid !== 1'b0) $display("FAIL seqkill_valid: got %b want 0", ifid_valid); else n_pass++;
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++; if (ifid_pc !== 32'h88) $display("FAIL seqkill_after_pc: got %h want %h", ifid_pc, 32'h88); else n_pass++;
        n_checks++; if (ifid_valid !== 1'b1) $display("FAIL seqkill_after_valid: got %b want 1", ifid_valid); else n_pass++;
    endtask

    task automatic test_stall();
        jump_target = 32'h200;
        drive(3'b001, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (pc !== 32'h8C) $display("FAIL stall_pc: got %h want %h", pc, 32'h8C); else n_pass++;
            n_checks++; if (ifid_pc !== 32'h88) $display("FAIL stall_ifid_pc: got %h want %h", ifid_pc, 32'h88); else n_pass++;
            n_checks++; if (ifid_valid !== 1'b1) $display("FAIL stall_valid: got %b want 1", ifid_valid); else n_pass++;
            n_checks++; if (ifid_instr !== imem(32'h88)) $display("FAIL stall_instr: got %h want %h", ifid_instr, imem(32'h88)); else n_pass++;
        end
        drive(3'b001, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++; if (pc !== 32'h200) $display("FAIL unstall_pc: got %h want %h", pc, 32'h200); else n_pass++;
        n_checks++; if (ifid_valid !== 1'b0) $display("FAIL unstall_valid: got %b want 0", ifid_valid); else n_pass++;
        n_checks++; if (ifid_pc !== 32'h8C) $display("FAIL unstall_ifid_pc: got %h want %h", ifid_pc, 32'h8C); else n_pass++;
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++; if (pc !== 32'h204) $display("FAIL unstall_next_pc: got %h want %h", pc, 32'h204); else n_pass++;
    endtask

`ifdef PC_FETCH_RAS_EN
    task automatic test_ras_call_ret();
        ret_target  = 32'h7770;
        jump_target = 32'h20;
        drive(3'b001, 1'b1, 1'b0, 1'b0);
        tick();
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++; if (ifid_pc !== 32'h20) $display("FAIL call_setup_ifid_pc: got %h want %h", ifid_pc, 32'h20); else n_pass++;
        jump_target = 32'h100;
        drive(3'b001, 1'b1, 1'b1, 1'b0);
        tick();
        n_checks++; if (pc !== 32'h100) $display("FAIL call_pc: got %h want %h", pc, 32'h100); else n_pass++;
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        tick();
        drive(3'b100, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++; if (pc !== 32'h24) $display("FAIL ret_pc: got %h want %h", pc, 32'h24); else n_pass++;
        n_checks++; if (ras_overflow !== 1'b0) $display("FAIL ret_ovf: got %b want 0", ras_overflow); else n_pass++;
        n_checks++; if (ras_underflow !== 1'b0) $display("FAIL ret_unf: got %b want 0", ras_underflow); else n_pass++;
        // The stack must be empty again, so another Ret underflows.
        tick();
        n_checks++; if (pc !== 32'h0) $display("FAIL empty_ret_pc: got %h want %h", pc, 32'h0); else n_pass++;
        n_checks++; if (ras_underflow !== 1'b1) $display("FAIL empty_ret_unf: got %b want 1", ras_underflow); else n_pass++;
        n_checks++; if (ras_overflow !== 1'b0) $display("FAIL empty_ret_ovf: got %b want 0", ras_overflow); else n_pass++;
        drive(3'b000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_ras_overflow();
        logic [31:0] exp_ifid;
        logic [31:0] exp_pc;
        logic [31:0] want;
        rst_n = 1'b0;
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        n_checks++; if (ras_underflow !== 1'b0) $display("FAIL ovf_reset_unf: got %b want 0", ras_underflow); else n_pass++;
        tick();
        tick();
        exp_pc   = 32'h8;
        exp_ifid = 32'h4;
        exp_q.delete();
        for (int k = 1; k <= 9; k++) begin
            rs1_target = 32'(32'h1000 * k);
            drive(3'b011, 1'b1, 1'b0, 1'b0);
            exp_q.push_back(exp_ifid + 32'd4);
            if (exp_q.size() > 8) void'(exp_q.pop_front());
            tick();
            exp_ifid = exp_pc;
            exp_pc   = rs1_target;
            n_checks++; if (pc !== exp_pc) $display("FAIL push_pc: got %h want %h", pc, exp_pc); else n_pass++;
            n_checks++; if (ras_overflow !== (k == 9)) $display("FAIL push_ovf k=%0d: got %b want %b", k, ras_overflow, (k == 9)); else n_pass++;
        end
        drive(3'b100, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            want = (exp_q.size() > 0) ? exp_q.pop_back() : 32'h0;
            tick();
            n_checks++; if (pc !== want) $display("FAIL pop_pc k=%0d: got %h want %h", k, pc, want); else n_pass++;
            n_checks++; if (ras_underflow !== (k == 9)) $display("FAIL pop_unf k=%0d: got %b want %b", k, ras_underflow, (k == 9)); else n_pass++;
        end
        n_checks++; if (ras_overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ras_overflow); else n_pass++;
        drive(3'b000, 1'b0, 1'b0, 1'b0);
    endtask
`else
    task automatic test_ret_input();
        ret_target = 32'h3000;
        drive(3'b100, 1'b1, 1'b1, 1'b0);
        tick();
        n_checks++; if (pc !== 32'h3000) $display("FAIL ret_in_pc: got %h want %h", pc, 32'h3000); else n_pass++;
        n_checks++; if (ifid_valid !== 1'b0) $display("FAIL ret_in_valid: got %b want 0", ifid_valid); else n_pass++;
        ret_target = 32'h4000;
        tick();
        n_checks++; if (pc !== 32'h4000) $display("FAIL ret_in_pc2: got %h want %h", pc, 32'h4000); else n_pass++;
        n_checks++; if (ras_overflow !== 1'b0) $display("FAIL ret_in_ovf: got %b want 0", ras_overflow); else n_pass++;
        n_checks++; if (ras_underflow !== 1'b0) $display("FAIL ret_in_unf: got %b want 0", ras_underflow); else n_pass++;
        drive(3'b000, 1'b0, 1'b0, 1'b0);
    endtask
`endif

    task automatic test_wrap();
        jump_target = 32'hFFFF_FFFC;
        drive(3'b001, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++; if (pc !== 32'hFFFF_FFFC) $display("FAIL wrap_setup_pc: got %h want %h", pc, 32'hFFFF_FFFC); else n_pass++;
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++; if (pc !== 32'h0) $display("FAIL wrap_pc: got %h want %h", pc, 32'h0); else n_pass++;
        n_checks++; if (ifid_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_ifid_pc: got %h want %h", ifid_pc, 32'hFFFF_FFFC); else n_pass++;
        n_checks++; if (ifid_instr !== imem(32'hFFFF_FFFC)) $display("FAIL wrap_instr: got %h want %h", ifid_instr, imem(32'hFFFF_FFFC)); else n_pass++;
    endtask

    task automatic test_reset_during_kill();
        tick();
        branch_target = 32'h500;
        drive(3'b010, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        n_checks++; if (pc !== 32'h0) $display("FAIL rstkill_pc: got %h want %h", pc, 32'h0); else n_pass++;
        n_checks++; if (ifid_pc !== 32'h0) $display("FAIL rstkill_ifid_pc: got %h want %h", ifid_pc, 32'h0); else n_pass++;
        n_checks++; if (ifid_valid !== 1'b0) $display("FAIL rstkill_valid: got %b want 0", ifid_valid); else n_pass++;
        n_checks++; if (ifid_instr !== NOP) $display("FAIL rstkill_instr: got %h want %h", ifid_instr, NOP); else n_pass++;
        n_checks++; if (ras_overflow !== 1'b0) $display("FAIL rstkill_ovf: got %b want 0", ras_overflow); else n_pass++;
        n_checks++; if (ras_underflow !== 1'b0) $display("FAIL rstkill_unf: got %b want 0", ras_underflow); else n_pass++;
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        n_checks++; if (pc !== 32'h4) $display("FAIL post_reset_pc: got %h want %h", pc, 32'h4); else n_pass++;
    endtask

    initial begin
        rst_n         = 1'b0;
        jump_target   = '0;
        branch_target = '0;
        rs1_target    = '0;
        ret_target    = '0;
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_sequential();
        test_branch_kill();
        test_stall();
`ifdef PC_FETCH_RAS_EN
        test_ras_call_ret();
        test_ras_overflow();
`else
        test_ret_input();
`endif
        test_wrap();
        test_reset_during_kill();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
